// File: rtl/mux2_1_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the
// downstream consumer of the registered 2:1 mux output.
interface mux2_1_rr_arbiter_if #(
    parameter int DATA_W = 2
);
    logic              valid0;
    logic [DATA_W-1:0] data_in0;
    logic              ready0;
    logic              valid1;
    logic [DATA_W-1:0] data_in1;
    logic              ready1;
    logic              ready_out;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              selector;

    modport master (
        output valid0, data_in0,
        output valid1, data_in1,
        output ready_out,
        input  ready0, ready1,
        input  valid_out, data_out,
        input  selector
    );

    modport slave (
        input  valid0, data_in0,
        input  valid1, data_in1,
        input  ready_out,
        output ready0, ready1,
        output valid_out, data_out,
        output selector
    );
endinterface

// File: rtl/mux2_1_rr_arbiter.sv
// Round-robin arbiter driving a registered 2:1 mux with a burst limit.
// Define ARB_STATS_EN to add per-requester transfer counters.
module mux2_1_rr_arbiter #(
    parameter int DATA_W    = 2,
    parameter int MAX_BURST = 4
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W     = 7
`endif
) (
    input  logic                 clk,
    input  logic                 reset_L,
    mux2_1_rr_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        burst_cnt;
    logic [3:0]        burst_nxt;
    logic [3:0]        burst_inc;
    logic              last_grant;
    logic              last_nxt;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              slot_free;
    logic              rdy0;
    logic              rdy1;
    logic              xfer0;
    logic              xfer1;

    assign slot_free = !valid_q || bus.ready_out;

    assign rdy0 = reset_L && (state == GRANT0) && slot_free;
    assign rdy1 = reset_L && (state == GRANT1) && slot_free;

    assign xfer0 = bus.valid0 && rdy0;
    assign xfer1 = bus.valid1 && rdy1;

    assign bus.ready0    = rdy0;
    assign bus.ready1    = rdy1;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.selector  = (state == GRANT1);

    // A lone requester saturates here and keeps the grant.
    assign burst_inc = (burst_cnt == LAST) ? burst_cnt
                                           : burst_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        last_nxt  = last_grant;
        unique case (state)
            IDLE: begin
                if (bus.valid0 && bus.valid1)
                    state_nxt = last_grant ? GRANT0 : GRANT1;
                else if (bus.valid0)
                    state_nxt = GRANT0;
                else if (bus.valid1)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                if (xfer0 && burst_cnt == LAST && bus.valid1) begin
                    state_nxt = GRANT1;
                    burst_nxt = 4'd0;
                    last_nxt  = 1'b0;
                end else if (xfer0) begin
                    burst_nxt = burst_inc;
                end else if (!bus.valid0) begin
                    burst_nxt = 4'd0;
                    last_nxt  = 1'b0;
                    state_nxt = bus.valid1 ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (xfer1 && burst_cnt == LAST && bus.valid0) begin
                    state_nxt = GRANT0;
                    burst_nxt = 4'd0;
                    last_nxt  = 1'b1;
                end else if (xfer1) begin
                    burst_nxt = burst_inc;
                end else if (!bus.valid1) begin
                    burst_nxt = 4'd0;
                    last_nxt  = 1'b1;
                    state_nxt = bus.valid0 ? GRANT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            last_grant <= last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (xfer0) begin
            valid_q <= 1'b1;
            data_q  <= bus.data_in0;
        end else if (xfer1) begin
            valid_q <= 1'b1;
            data_q  <= bus.data_in1;
        end else if (bus.ready_out) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (xfer0)
                grant_cnt0 <= grant_cnt0 + 1'b1;
            if (xfer1)
                grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_1_rr_arbiter.sv
// Bench for mux2_1_rr_arbiter: reference model, output scoreboard
// and directed scenarios; optional counters under ARB_STATS_EN.
module tb_mux2_1_rr_arbiter;

    localparam int DATA_W    = 2;
    localparam int MAX_BURST = 4;

    logic clk_probador = 1'b0;
    logic reset_L;

    always #5 clk_probador = ~clk_probador;

    mux2_1_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
    logic [6:0] grant_cnt0;
    logic [6:0] grant_cnt1;
`endif

    mux2_1_rr_arbiter #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk_probador),
        .reset_L    (reset_L),
        .bus        (bus)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: 0 idle, 1 grant0, 2 grant1.
    int         m_state = 0;
    int         m_cnt   = 0;
    bit         m_last  = 1'b1;
    bit         m_vout  = 1'b0;
    logic [1:0] m_dout  = 2'b00;

    logic [1:0] sb[$];
    logic [1:0] seen[$];
    bit         capture = 1'b0;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
    endtask

    task automatic drive(bit v0, logic [1:0] d0,
                         bit v1, logic [1:0] d1, bit ro);
        bus.valid0    = v0;
        bus.data_in0  = d0;
        bus.valid1    = v1;
        bus.data_in1  = d1;
        bus.ready_out = ro;
    endtask

    task automatic cycle();
        bit sf, r0, r1, x0, x1, xg;
        bit v[2];
        int g, o;
        @(negedge clk_probador);
        sf = !m_vout || bus.ready_out;
        r0 = reset_L && (m_state == 1) && sf;
        r1 = reset_L && (m_state == 2) && sf;
        chk("ready0", bus.ready0, r0);
        chk("ready1", bus.ready1, r1);
        chk("valid_out", bus.valid_out, m_vout);
        chk("data_out", bus.data_out, m_dout);
        chk("selector", bus.selector, m_state == 2);
        if (bus.valid_out && bus.ready_out) begin
            if (sb.size() == 0)
                chk("sb_underflow", sb.size(), 1);
            else
                chk("sb_data", bus.data_out, sb.pop_front());
            if (capture)
                seen.push_back(bus.data_out);
        end
        x0 = bus.valid0 && r0;
        x1 = bus.valid1 && r1;
        @(posedge clk_probador);
        if (!reset_L) begin
            m_state = 0;
            m_cnt   = 0;
            m_last  = 1'b1;
            m_vout  = 1'b0;
            m_dout  = 2'b00;
            sb.delete();
        end else begin
            if (x0) begin
                m_dout = bus.data_in0;
                m_vout = 1'b1;
                sb.push_back(bus.data_in0);
            end else if (x1) begin
                m_dout = bus.data_in1;
                m_vout = 1'b1;
                sb.push_back(bus.data_in1);
            end else if (bus.ready_out) begin
                m_vout = 1'b0;
            end
            v[0] = bus.valid0;
            v[1] = bus.valid1;
            if (m_state == 0) begin
                if (v[0] && v[1])
                    m_state = m_last ? 1 : 2;
                else if (v[0])
                    m_state = 1;
                else if (v[1])
                    m_state = 2;
            end else begin
                g  = m_state - 1;
                o  = 1 - g;
                xg = (g == 1) ? x1 : x0;
                if (xg && m_cnt == MAX_BURST - 1 && v[o]) begin
                    m_state = o + 1;
                    m_cnt   = 0;
                    m_last  = (g == 1);
                end else if (xg) begin
                    if (m_cnt < MAX_BURST - 1)
                        m_cnt++;
                end else if (!v[g]) begin
                    m_cnt   = 0;
                    m_last  = (g == 1);
                    m_state = v[o] ? o + 1 : 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 2'b00, 1'b1);
        @(posedge clk_probador);
        #1;

        // Reset held with both requesters active.
        repeat (2) begin
            cycle();
            chk("rst_ready0", bus.ready0, 0);
            chk("rst_ready1", bus.ready1, 0);
            chk("rst_vout", bus.valid_out, 0);
            chk("rst_dout", bus.data_out, 0);
        end

        // Single requester.
        reset_L = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        cycle();
        chk("single_ready0", bus.ready0, 1);
        cycle();
        chk("single_vout", bus.valid_out, 1);
        chk("single_dout", bus.data_out, 2'b10);
        chk("single_sel", bus.selector, 0);
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        repeat (2) cycle();

        // Contention from a fresh reset.
        reset_L = 1'b0;
        cycle();
        reset_L = 1'b1;
        capture = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
        repeat (17) cycle();
        capture = 1'b0;
        chk("cont_count", seen.size() >= 12, 1);
        for (int k = 0; k < 12 && k < seen.size(); k++)
            chk("cont_seq", seen[k],
                ((k / 4) % 2 == 0) ? 2'b01 : 2'b11);
`ifdef ARB_STATS_EN
        chk("stats_cnt0", grant_cnt0, 8);
        chk("stats_cnt1", grant_cnt1, 8);
`endif

        // Backpressure on the granted requester.
        drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        cycle();
        bus.ready_out = 1'b0;
        #1;
        chk("bp_ready0", bus.ready0, 0);
        repeat (3) begin
            cycle();
            chk("bp_ready0_hold", bus.ready0, 0);
            chk("bp_vout", bus.valid_out, 1);
            chk("bp_dout", bus.data_out, 2'b10);
        end
        bus.ready_out = 1'b1;
        #1;
        chk("bp_resume", bus.ready0, 1);
        repeat (2) cycle();

        // Requester 0 drops after two transfers.
        reset_L = 1'b0;
        cycle();
        reset_L = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
        repeat (3) cycle();
        bus.valid0 = 1'b0;
        cycle();
        chk("drop_ready1", bus.ready1, 1);
        chk("drop_sel", bus.selector, 1);
        repeat (2) cycle();

        // Reset mid-burst.
        reset_L = 1'b0;
        #1;
        chk("midrst_ready1", bus.ready1, 0);
        cycle();
        chk("midrst_vout", bus.valid_out, 0);
        chk("midrst_sel", bus.selector, 0);
        reset_L = 1'b1;
        repeat (2) cycle();

        // Lone requester for 128 transfers.
        reset_L = 1'b0;
        cycle();
        reset_L = 1'b1;
        drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 129; i++) begin
            bus.data_in1 = 2'(i);
            cycle();
        end
`ifdef ARB_STATS_EN
        chk("wrap_cnt1", grant_cnt1, 0);
        chk("wrap_cnt0", grant_cnt0, 0);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset_L = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 3) != 0),
                  2'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  2'($urandom),
                  1'($urandom_range(0, 3) != 0));
            cycle();
        end

        reset_L = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
